// File: rtl/lfo_rate_sequencer.sv
// Sequences the triangle LFO generator: owns start/frequency code and defers rate changes to turn points.
// Optional LFO_SEQ_STEP_EN adds i_rate_up/i_rate_down single-step request pulses.
module lfo_rate_sequencer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_req_valid,
   input  logic [2:0] i_req_freq,
`ifdef LFO_SEQ_STEP_EN
   input  logic       i_rate_up,
   input  logic       i_rate_down,
`endif
   output logic       o_req_ready,
   output logic       o_start,
   output logic [2:0] o_freq,
   output logic       o_turn,
   output logic       o_dir,
   output logic       o_commit
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  pending, pending_n, freq_n;
   logic        start_n, turn_n, dir_n, commit_n, ready_n;
   logic        req_take, at_turn;
   logic [2:0]  req_code;

   function automatic logic [15:0] half_max(input logic [2:0] code);
      case (code)
         3'd0:    half_max = 16'd50000;
         3'd1:    half_max = 16'd25000;
         3'd2:    half_max = 16'd16666;
         3'd3:    half_max = 16'd12500;
         3'd4:    half_max = 16'd10000;
         3'd5:    half_max = 16'd8333;
         3'd6:    half_max = 16'd7143;
         default: half_max = 16'd6250;
      endcase
   endfunction

`ifdef LFO_SEQ_STEP_EN
   logic [2:0] step_code;

   // A saturated step leaves the code unchanged, so it is dropped as an equal-code request.
   always_comb begin
      step_code = o_freq;
      if (i_rate_up && !i_rate_down && o_freq != 3'd7)
         step_code = o_freq + 3'd1;
      else if (i_rate_down && !i_rate_up && o_freq != 3'd0)
         step_code = o_freq - 3'd1;
   end

   assign req_take = o_req_ready & (i_req_valid | (i_rate_up ^ i_rate_down));
   assign req_code = i_req_valid ? i_req_freq : step_code;
`else
   assign req_take = o_req_ready & i_req_valid;
   assign req_code = i_req_freq;
`endif

   assign at_turn = (cnt == half_max(o_freq));

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      pending_n = pending;
      freq_n    = o_freq;
      start_n   = o_start;
      turn_n    = 1'b0;
      dir_n     = o_dir;
      commit_n  = 1'b0;
      ready_n   = o_req_ready;
      case (state)
         IDLE: begin
            ready_n = 1'b1;
            cnt_n   = '0;
            start_n = 1'b0;
            if (req_take) begin
               freq_n   = req_code;
               commit_n = (req_code != o_freq);
            end
            if (i_enable) begin
               state_n = RUN;
               start_n = 1'b1;
               dir_n   = 1'b0;
            end
         end
         RUN, PEND: begin
            if (!i_enable) begin
               state_n   = IDLE;
               start_n   = 1'b0;
               cnt_n     = '0;
               dir_n     = 1'b0;
               pending_n = '0;
               ready_n   = 1'b1;
            end else begin
               cnt_n = cnt + 16'd1;
               if (at_turn) begin
                  cnt_n  = '0;
                  dir_n  = ~o_dir;
                  turn_n = 1'b1;
                  if (state == PEND) begin
                     freq_n   = pending;
                     commit_n = 1'b1;
                     state_n  = RUN;
                     ready_n  = 1'b1;
                  end
               end
               // Acceptance on a turn edge still compares against the old code and waits a full half-period.
               if (state == RUN && req_take && req_code != o_freq) begin
                  pending_n = req_code;
                  state_n   = PEND;
                  ready_n   = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         pending     <= '0;
         o_freq      <= '0;
         o_start     <= 1'b0;
         o_turn      <= 1'b0;
         o_dir       <= 1'b0;
         o_commit    <= 1'b0;
         o_req_ready <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         pending     <= pending_n;
         o_freq      <= freq_n;
         o_start     <= start_n;
         o_turn      <= turn_n;
         o_dir       <= dir_n;
         o_commit    <= commit_n;
         o_req_ready <= ready_n;
      end
   end

endmodule

// File: tb/tb_lfo_rate_sequencer.sv
// Randomized bench for lfo_rate_sequencer against an event-time reference model (turn times as absolute cycles).
// Builds with or without LFO_SEQ_STEP_EN.
module tb_lfo_rate_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_freq = '0;
   logic       rate_up = 1'b0;
   logic       rate_down = 1'b0;
   logic       req_ready, start, turn, dir, commit;
   logic [2:0] freq;

   int checks = 0;
   int failures = 0;

   // reference model state
   int t = 0;
   int next_turn = 0;
   int m_freq = 0;
   int m_pcode = 0;
   bit m_run = 0, m_dir = 0, m_turn = 0, m_commit = 0, m_ready = 0, m_pend = 0;
   int half_tab [8] = '{50000, 25000, 16666, 12500, 10000, 8333, 7143, 6250};

   lfo_rate_sequencer dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_enable    (enable),
      .i_req_valid (req_valid),
      .i_req_freq  (req_freq),
`ifdef LFO_SEQ_STEP_EN
      .i_rate_up   (rate_up),
      .i_rate_down (rate_down),
`endif
      .o_req_ready (req_ready),
      .o_start     (start),
      .o_freq      (freq),
      .o_turn      (turn),
      .o_dir       (dir),
      .o_commit    (commit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, t, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_dir = 0; m_turn = 0; m_commit = 0; m_ready = 0; m_pend = 0;
      m_freq = 0; m_pcode = 0; next_turn = 0;
   endtask

   task automatic model_step();
      bit acc, was_pend;
      int code, old_freq;
      t++;
      acc = 0;
      code = int'(req_freq);
      if (m_ready) begin
         if (req_valid) acc = 1;
`ifdef LFO_SEQ_STEP_EN
         else if (rate_up ^ rate_down) begin
            acc = 1;
            code = rate_up ? ((m_freq == 7) ? 7 : m_freq + 1) : ((m_freq == 0) ? 0 : m_freq - 1);
         end
`endif
      end
      m_turn = 0;
      m_commit = 0;
      if (!m_run) begin
         m_ready = 1;
         if (acc) begin
            m_commit = (code != m_freq);
            m_freq = code;
         end
         if (enable) begin
            m_run = 1;
            m_dir = 0;
            next_turn = t + half_tab[m_freq] + 1;
         end
      end else if (!enable) begin
         m_run = 0; m_dir = 0; m_pend = 0; m_ready = 1;
      end else begin
         was_pend = m_pend;
         old_freq = m_freq;
         if (t == next_turn) begin
            m_turn = 1;
            m_dir = !m_dir;
            if (m_pend) begin
               m_freq = m_pcode;
               m_commit = 1;
               m_pend = 0;
               m_ready = 1;
            end
            next_turn = t + half_tab[m_freq] + 1;
         end
         if (!was_pend && acc && code != old_freq) begin
            m_pend = 1;
            m_pcode = code;
            m_ready = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("start",  32'(start),     32'(m_run));
      check("freq",   32'(freq),      32'(m_freq));
      check("turn",   32'(turn),      32'(m_turn));
      check("dir",    32'(dir),       32'(m_dir));
      check("commit", 32'(commit),    32'(m_commit));
      check("ready",  32'(req_ready), 32'(m_ready));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic request(input int code);
      req_valid = 1'b1;
      req_freq  = 3'(code);
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      model_reset();
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      #1 check("ready_before_first_edge", 32'(req_ready), 32'd0);
      step();
      check("ready_after_release", 32'(req_ready), 32'd1);

      // free run at code 7, equal-code drop, deferred change to 3
      request(7);
      enable = 1'b1;
      step();
      for (int i = 0; i < 60; i++) step();
      request(7);
`ifdef LFO_SEQ_STEP_EN
      rate_up = 1'b1; step(); rate_up = 1'b0;
      rate_up = 1'b1; rate_down = 1'b1; step(); rate_up = 1'b0; rate_down = 1'b0;
`endif
      for (int i = 0; i < 30; i++) step();
      request(3);
      for (int i = 0; i < 19000; i++) step();

      // abort a pending change 10 cycles before its turn
      request(0);
      for (int i = 0; i < 60000 && (t + 1 < next_turn - 10); i++) step();
      enable = 1'b0;
      step();
      for (int i = 0; i < 20; i++) step();

      // enable together with request, then drop enable exactly on the PEND turn edge
      enable = 1'b1;
      request(6);
      for (int i = 0; i < 50; i++) step();
      request(5);
      for (int i = 0; i < 60000 && (t + 1 < next_turn); i++) step();
      enable = 1'b0;
      step();
      for (int i = 0; i < 10; i++) step();

      // randomized phase
      enable = 1'b1;
      for (int i = 0; i < 30000; i++) begin
         if ($urandom_range(3999, 0) == 0) enable = ~enable;
         req_valid = ($urandom_range(199, 0) == 0);
         req_freq  = 3'($urandom_range(7, 4));
`ifdef LFO_SEQ_STEP_EN
         rate_up   = ($urandom_range(299, 0) == 0);
         rate_down = ($urandom_range(299, 0) == 0);
`endif
         step();
      end
      req_valid = 1'b0;
      rate_up = 1'b0;
      rate_down = 1'b0;

      // asynchronous reset in the middle of a run
      enable = 1'b1;
      for (int i = 0; i < 40; i++) step();
      rst = 1'b1;
      #1 model_reset();
      compare_all();
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      enable = 1'b0;
      step();
      check("ready_after_mid_reset", 32'(req_ready), 32'd1);
      for (int i = 0; i < 5; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lfo_rate_sequencer.md
# lfo_rate_sequencer

Controller that sequences the triangle LFO generator in the modulation path. It owns the generator's `start` and 3-bit frequency code. Rate-change requests are accepted over a valid/ready handshake. A new rate is committed only at a waveform turn point, so the LFO never jumps mid-slope. A mirror half-period counter, using the same per-code half-period table as the generator, tracks the turn points.

## Interface
- No parameters; half-period table fixed: code 0..7 -> HALF_MAX = 50000, 25000, 16666, 12500, 10000, 8333, 7143, 6250.
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  level; 1 = LFO running
- i_req_valid  in  1  rate-change request valid
- i_req_freq  in  3  requested frequency code (0 = 1 Hz … 7 = 8 Hz)
- o_req_ready  out  1  request can be accepted this cycle (registered)
- o_start  out  1  drives generator start (registered)
- o_freq  out  3  committed frequency code to generator (registered)
- o_turn  out  1  1-cycle pulse at each turn point (registered)
- o_dir  out  1  current slope, 1 = rising; toggles at each turn
- o_commit  out  1  1-cycle pulse when a new o_freq takes effect
- i_rate_up, i_rate_down  in  1  single-cycle step pulses; present only with LFO_SEQ_STEP_EN

## Operation
- Reset values: state IDLE, o_start=0, o_freq=0, o_turn=0, o_dir=0, o_commit=0, o_req_ready=0, cnt=0, pending=0.
- Transfer occurs on a rising edge with i_req_valid & o_req_ready.
- IDLE:
  - o_start=0, cnt held at 0, o_req_ready=1.
  - Accepted request: o_freq<=i_req_freq next cycle, with an o_commit pulse if the code differs.
  - i_enable=1 -> RUN; o_start=1, cnt=0, o_dir=0.
- RUN:
  - cnt increments by 1 each cycle.
  - When cnt==HALF_MAX[o_freq]: cnt<=0, o_dir toggles, o_turn pulses.
  - Accepted request with code != o_freq: latch pending, go to PEND, o_req_ready<=0.
  - Accepted request with code == o_freq: dropped; stay in RUN with no pulse.
- PEND:
  - Counting continues with the old code.
  - At the turn: o_freq<=pending, cnt<=0, o_dir toggles, o_turn and o_commit pulse together, go to RUN, o_req_ready<=1.
- i_enable=0 in RUN/PEND: next state IDLE, o_start<=0, cnt<=0, o_dir<=0. Any pending request is discarded; o_freq keeps its last committed value.
- Widths: cnt is 16 bits unsigned; the compare uses HALF_MAX of the currently committed code.

## Timing
- Each half-period in RUN lasts HALF_MAX+1 cycles. The first o_turn comes HALF_MAX+1 cycles after the edge where o_start rises.
- Request-to-commit latency:
  - IDLE: 1 cycle.
  - RUN: waits for the first turn strictly after the acceptance edge. A request accepted on a turn edge waits for the following turn.
- After a commit, the next half-period uses the new HALF_MAX.
- Simultaneous events:
  - i_enable falling on a PEND turn edge: IDLE wins, no commit, no o_turn.
  - i_enable rising together with an accepted request in IDLE: both apply. RUN starts with the requested code.
- Reset asserted mid-operation: all registers return to reset values immediately. o_req_ready first rises 1 cycle after reset release.

## Configuration
- LFO_SEQ_STEP_EN defined:
  - Ports i_rate_up/i_rate_down exist. Each pulse forms an internal request of o_freq±1, saturating at 7 and 0.
  - The internal request is taken only when o_req_ready=1 and i_req_valid=0; the external request has priority and the step pulse is lost.
  - Simultaneous up and down pulses are ignored. A saturated step is treated as an equal-code request and dropped.
- Undefined: step ports absent; only the external handshake changes rate.

## Test plan
- Reset check: assert i_rst mid-RUN -> all outputs 0 at once. o_req_ready=1 on the first cycle after release.
- Free run at code 7: raise i_enable -> o_start=1. o_turn at +6251 and +12502 cycles; o_dir goes 1 then 0.
- Deferred change: code 7 running, request code 3 at cycle 100 -> o_req_ready=0 until turn at 6251. o_commit and o_turn coincide there, o_freq=3, next turn at 6251+12501.
- Equal-code drop: request code 7 while running at 7 -> accepted; o_req_ready stays 1, no o_commit, turn spacing unchanged.
- Abort: request code 0 pending, drop i_enable 10 cycles before turn -> IDLE, o_start=0, o_freq stays 7, no o_commit ever.
- LFO_SEQ_STEP_EN: at code 7 pulse i_rate_up -> dropped, no commit. Pulse i_rate_down -> commit to 6 at next turn. Up+down in the same cycle -> nothing.
